// File: rtl/i2s_stereo_tx.sv
// fifo: generic small synchronous FIFO. Depth and data width are set by parameters.
// Latency: the head entry is visible on pop_dat the cycle after it is pushed.
// Backpressure: push_rdy deasserts when full; a pop and a push in the same cycle are both taken.
// Ports: clk/reset; push_vld/push_rdy/push_dat (write side); pop, pop_vld, pop_dat (head of queue).
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign push_rdy = (count < CW'(DEPTH));
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop && pop_vld;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end
endmodule

// i2s_stereo_tx: buffers stereo PCM pairs in a 2-entry FIFO and serializes them as an I2S DAC stream.
// Latency: a pair pushed before a frame's slot-0 falling sclk edge goes out in that frame (MSB one sclk after lrclk falls).
// Backpressure: in_ready = FIFO not full; an empty FIFO at frame start sends silence and pulses underrun.
// Ports: clk/reset; in_valid/in_ready/in_left/in_right sample input;
//        mclk, sclk, lrclk, sdin codec pins; underrun pulse and saturating underrun_count.
module i2s_stereo_tx #(
  parameter int WIDTH     = 16,
  parameter int SCLK_HALF = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             mclk,
  output logic             sclk,
  output logic             lrclk,
  output logic             sdin,
  output logic             underrun,
  output logic [15:0]      underrun_count
);
  localparam int SLOTS = 2 * WIDTH;
  localparam int SW    = $clog2(SLOTS);
  localparam int DW    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [DW-1:0]      d;
  logic [SW-1:0]      b;
  logic [SW-1:0]      b_nxt;
  logic [SLOTS-1:0]   sh;
  logic               d_wrap;
  logic               fall;
  logic               frame_start;
  logic               fifo_vld;
  logic [SLOTS-1:0]   fifo_dat;

  assign d_wrap      = (d == DW'(SCLK_HALF-1));
  // Data and word select only move on the sclk falling edge so they are stable at the rise.
  assign fall        = d_wrap && sclk;
  assign b_nxt       = (b == SW'(SLOTS-1)) ? '0 : b + SW'(1);
  assign frame_start = fall && (b_nxt == '0);

  fifo #(
    .WIDTH (SLOTS),
    .DEPTH (2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat ({in_left, in_right}),
    .pop      (frame_start),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_dat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mclk           <= 1'b0;
      sclk           <= 1'b0;
      d              <= '0;
      b              <= SW'(SLOTS-1);
      lrclk          <= 1'b1;
      sdin           <= 1'b0;
      sh             <= '0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      mclk     <= ~mclk;
      underrun <= 1'b0;
      if (d_wrap) begin
        d    <= '0;
        sclk <= ~sclk;
      end else begin
        d <= d + DW'(1);
      end
      if (fall) begin
        b     <= b_nxt;
        lrclk <= (b_nxt >= SW'(WIDTH));
        // Slot 0 emits the right-word LSB left at the top of the register after
        // 2*WIDTH-1 shifts: this is the one-bit I2S delay spilling into the next frame.
        sdin  <= sh[SLOTS-1];
        if (b_nxt == '0) begin
          if (fifo_vld) begin
            sh <= fifo_dat;
          end else begin
            sh       <= '0;
            underrun <= 1'b1;
            if (underrun_count != 16'hFFFF) begin
              underrun_count <= underrun_count + 16'd1;
            end
          end
        end else begin
          sh <= {sh[SLOTS-2:0], 1'b0};
        end
      end
    end
  end
endmodule
